// File: rtl/cmd_frame_pkg.sv
// Shared definitions for the command-frame controller: opcodes, FSM states,
// operand register addresses and the result byte-count helper.
package cmd_frame_pkg;

   // Opcodes, zero-extended to DATA_WIDTH before comparison.
   localparam logic [7:0] CMD_WR      = 8'hAA;
   localparam logic [7:0] CMD_RD      = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   // Register-file locations that hold the ALU operands.
   localparam int REG_A = 0;
   localparam int REG_B = 1;

   typedef enum logic [3:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_WAIT,
      OP_A,
      OP_B,
      ALU_FUN_S,
      ALU_WAIT,
      TX_SEND
   } state_t;

   // Number of TX bytes needed to carry a result of out_w bits.
   function automatic int nbytes(input int out_w, input int data_w);
      return (out_w + data_w - 1) / data_w;
   endfunction

endpackage

// File: rtl/cmd_frame_ctrl_tx_byte_serializer.sv
// Sends a latched result to the TX FIFO one byte at a time, LSB first,
// stalling without loss while the FIFO reports full.
module tx_byte_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BYTES  = 2,
   parameter int CNT_W      = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            load,
   input  logic [MAX_BYTES*DATA_WIDTH-1:0] load_data,
   input  logic [CNT_W-1:0]                load_count,
   input  logic                            fifo_full,
   output logic [DATA_WIDTH-1:0]           tx_data,
   output logic                            tx_vld,
   output logic                            last
);

   logic [MAX_BYTES*DATA_WIDTH-1:0] shreg;
   logic [CNT_W-1:0]                remaining;

   // The strobe is gated by fifo_full in the same cycle, so a byte is only
   // offered when the FIFO can take it; the data word sits still until then.
   assign tx_vld  = (remaining != '0) && !fifo_full;
   assign tx_data = shreg[DATA_WIDTH-1:0];
   assign last    = tx_vld && (remaining == CNT_W'(1));

   // Load a new result, or shift out one byte each cycle the FIFO accepts it.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // updates from the same pre-edge values and simulation matches hardware.
      if (rst) begin
         shreg     <= '0;
         remaining <= '0;
      end else if (load) begin
         shreg     <= load_data;
         remaining <= load_count;
      end else if (tx_vld) begin
         shreg     <= shreg >> DATA_WIDTH;
         remaining <= remaining - 1'b1;
      end
   end

endmodule

// File: rtl/cmd_frame_ctrl.sv
// Command-frame controller: parses opcode frames from the RX byte stream,
// drives register-file writes/reads and ALU operations, and returns results
// to the TX FIFO. Adds inter-byte timeout, address checking and RX overrun.
module cmd_frame_ctrl
   import cmd_frame_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int OUT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   input  logic [DATA_WIDTH-1:0] RdData,
   input  logic                  RdData_Valid,
   input  logic [OUT_WIDTH-1:0]  ALU_OUT,
   input  logic                  OUT_Valid,
   input  logic                  fifo_full,
   output logic [3:0]            ALU_FUN,
   output logic                  EN,
   output logic                  CLK_EN,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [DATA_WIDTH-1:0] WrData,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   output logic                  clk_div_en,
   output logic                  frame_err,
   output logic                  rx_overrun
);

   localparam int NB    = nbytes(OUT_WIDTH, DATA_WIDTH);
   localparam int RES_W = NB * DATA_WIDTH;
   localparam int CW    = $clog2(NB + 1);
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [DATA_WIDTH-1:0] OP_WR      = DATA_WIDTH'(CMD_WR);
   localparam logic [DATA_WIDTH-1:0] OP_RD      = DATA_WIDTH'(CMD_RD);
   localparam logic [DATA_WIDTH-1:0] OP_ALU     = DATA_WIDTH'(CMD_ALU_OP);
   localparam logic [DATA_WIDTH-1:0] OP_ALU_NOP = DATA_WIDTH'(CMD_ALU_NOP);
   localparam logic [TW-1:0]         TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   state_t                state, state_nx;
   logic [TW-1:0]         tmo_cnt, tmo_nx;
   logic                  wr_en_nx, rd_en_nx, en_nx, clk_en_nx;
   logic                  frame_err_nx, overrun_nx;
   logic [ADDR_WIDTH-1:0] addr_nx;
   logic [DATA_WIDTH-1:0] wr_data_nx;
   logic [3:0]            alu_fun_nx;
   logic                  ser_load, ser_last;
   logic [RES_W-1:0]      ser_data;
   logic [CW-1:0]         ser_count;
   logic                  in_frame, waiting, progress, tmo_hit, addr_ok;

   // States collecting frame bytes, and states waiting on a read/ALU strobe.
   assign in_frame = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR) ||
                     (state == OP_A) || (state == OP_B) || (state == ALU_FUN_S);
   assign waiting  = (state == RD_WAIT) || (state == ALU_WAIT);
   assign progress = (in_frame && RX_D_VLD) ||
                     ((state == RD_WAIT) && RdData_Valid) ||
                     ((state == ALU_WAIT) && OUT_Valid);
   assign tmo_hit  = (in_frame || waiting) && !progress && (tmo_cnt == TMO_LAST);
   assign addr_ok  = (RX_P_DATA >> ADDR_WIDTH) == '0;

   // Next-state and next-output decode for the frame parser.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nx     = state;
      tmo_nx       = (in_frame || waiting) ? tmo_cnt + 1'b1 : '0;
      wr_en_nx     = 1'b0;
      rd_en_nx     = 1'b0;
      en_nx        = 1'b0;
      clk_en_nx    = CLK_EN;
      frame_err_nx = 1'b0;
      overrun_nx   = 1'b0;
      addr_nx      = Address;
      wr_data_nx   = WrData;
      alu_fun_nx   = ALU_FUN;
      ser_load     = 1'b0;
      ser_data     = '0;
      ser_count    = '0;

      if (tmo_hit) begin
         state_nx     = IDLE;
         tmo_nx       = '0;
         frame_err_nx = 1'b1;
         clk_en_nx    = 1'b0;
      end else begin
         if (progress) tmo_nx = '0;
         unique case (state)
            IDLE: begin
               if (RX_D_VLD) begin
                  if      (RX_P_DATA == OP_WR)      state_nx = WR_ADDR;
                  else if (RX_P_DATA == OP_RD)      state_nx = RD_ADDR;
                  else if (RX_P_DATA == OP_ALU)     state_nx = OP_A;
                  else if (RX_P_DATA == OP_ALU_NOP) state_nx = ALU_FUN_S;
                  else                              frame_err_nx = 1'b1;
               end
            end
            WR_ADDR, RD_ADDR: begin
               if (RX_D_VLD) begin
                  if (addr_ok) begin
                     addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
                     rd_en_nx = (state == RD_ADDR);
                     state_nx = (state == RD_ADDR) ? RD_WAIT : WR_DATA;
                  end else begin
                     frame_err_nx = 1'b1;
                     state_nx     = IDLE;
                  end
               end
            end
            WR_DATA: begin
               if (RX_D_VLD) begin
                  wr_en_nx   = 1'b1;
                  wr_data_nx = RX_P_DATA;
                  state_nx   = IDLE;
               end
            end
            OP_A, OP_B: begin
               if (RX_D_VLD) begin
                  wr_en_nx   = 1'b1;
                  wr_data_nx = RX_P_DATA;
                  addr_nx    = (state == OP_A) ? ADDR_WIDTH'(REG_A) : ADDR_WIDTH'(REG_B);
                  state_nx   = (state == OP_A) ? OP_B : ALU_FUN_S;
               end
            end
            ALU_FUN_S: begin
               if (RX_D_VLD) begin
                  alu_fun_nx = RX_P_DATA[3:0];
                  en_nx      = 1'b1;
                  clk_en_nx  = 1'b1;
                  state_nx   = ALU_WAIT;
               end
            end
            RD_WAIT: begin
               overrun_nx = RX_D_VLD;
               if (RdData_Valid) begin
                  ser_load  = 1'b1;
                  ser_data  = RES_W'(RdData);
                  ser_count = CW'(1);
                  state_nx  = TX_SEND;
               end
            end
            ALU_WAIT: begin
               overrun_nx = RX_D_VLD;
               if (OUT_Valid) begin
                  ser_load  = 1'b1;
                  ser_data  = RES_W'(ALU_OUT);
                  ser_count = CW'(NB);
                  clk_en_nx = 1'b0;
                  state_nx  = TX_SEND;
               end
            end
            TX_SEND: begin
               overrun_nx = RX_D_VLD;
               if (ser_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // State, timeout counter and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         tmo_cnt    <= '0;
         WrEn       <= 1'b0;
         RdEn       <= 1'b0;
         EN         <= 1'b0;
         CLK_EN     <= 1'b0;
         frame_err  <= 1'b0;
         rx_overrun <= 1'b0;
         Address    <= '0;
         WrData     <= '0;
         ALU_FUN    <= '0;
         clk_div_en <= 1'b0;
      end else begin
         state      <= state_nx;
         tmo_cnt    <= tmo_nx;
         WrEn       <= wr_en_nx;
         RdEn       <= rd_en_nx;
         EN         <= en_nx;
         CLK_EN     <= clk_en_nx;
         frame_err  <= frame_err_nx;
         rx_overrun <= overrun_nx;
         Address    <= addr_nx;
         WrData     <= wr_data_nx;
         ALU_FUN    <= alu_fun_nx;
         clk_div_en <= 1'b1;
      end
   end

   tx_byte_serializer #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_BYTES  (NB),
      .CNT_W      (CW)
   ) u_ser (
      .clk        (CLK),
      .rst        (RST),
      .load       (ser_load),
      .load_data  (ser_data),
      .load_count (ser_count),
      .fifo_full  (fifo_full),
      .tx_data    (TX_P_DATA),
      .tx_vld     (TX_D_VLD),
      .last       (ser_last)
   );

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Scoreboard bench for cmd_frame_ctrl: directed frames push expected events,
// a negedge monitor pops and compares every output pulse it observes.
module tb_cmd_frame_ctrl;

   localparam int DW  = 8;
   localparam int AW  = 4;
   localparam int OW  = 16;
   localparam int TMO = 1024;

   localparam logic [7:0] K_WR   = 8'd1;
   localparam logic [7:0] K_RD   = 8'd2;
   localparam logic [7:0] K_EN   = 8'd3;
   localparam logic [7:0] K_TX   = 8'd4;
   localparam logic [7:0] K_FERR = 8'd5;
   localparam logic [7:0] K_OVR  = 8'd6;

   typedef struct packed {
      logic [7:0]  kind;
      logic [15:0] val;
   } evt_t;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [DW-1:0] RX_P_DATA = '0;
   logic          RX_D_VLD = 1'b0;
   logic [DW-1:0] RdData = '0;
   logic          RdData_Valid = 1'b0;
   logic [OW-1:0] ALU_OUT = '0;
   logic          OUT_Valid = 1'b0;
   logic          fifo_full = 1'b0;
   logic [3:0]    ALU_FUN;
   logic          EN, CLK_EN, WrEn, RdEn, TX_D_VLD, clk_div_en, frame_err, rx_overrun;
   logic [AW-1:0] Address;
   logic [DW-1:0] WrData, TX_P_DATA;
   logic [31:0]   outs;

   evt_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   cmd_frame_ctrl #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .OUT_WIDTH      (OW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .RX_P_DATA    (RX_P_DATA),
      .RX_D_VLD     (RX_D_VLD),
      .RdData       (RdData),
      .RdData_Valid (RdData_Valid),
      .ALU_OUT      (ALU_OUT),
      .OUT_Valid    (OUT_Valid),
      .fifo_full    (fifo_full),
      .ALU_FUN      (ALU_FUN),
      .EN           (EN),
      .CLK_EN       (CLK_EN),
      .Address      (Address),
      .WrEn         (WrEn),
      .RdEn         (RdEn),
      .WrData       (WrData),
      .TX_P_DATA    (TX_P_DATA),
      .TX_D_VLD     (TX_D_VLD),
      .clk_div_en   (clk_div_en),
      .frame_err    (frame_err),
      .rx_overrun   (rx_overrun)
   );

   assign outs = {ALU_FUN, EN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_DATA,
                  TX_D_VLD, clk_div_en, frame_err, rx_overrun};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] k, input logic [15:0] v);
      evt_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic observe(input string name, input logic [7:0] k, input logic [15:0] v);
      evt_t e;
      if (exp_q.size() == 0) begin
         check({"unexpected ", name}, {8'h0, k, v}, 32'h0);
      end else begin
         e = exp_q.pop_front();
         check(name, {8'h0, k, v}, {8'h0, e});
      end
   endtask

   // Monitor: every output pulse must match the oldest expected event.
   always @(negedge CLK) begin
      if (!RST) begin
         if (WrEn)       observe("wr", K_WR, {4'h0, Address, WrData});
         if (RdEn)       observe("rd", K_RD, {12'h0, Address});
         if (EN)         observe("alu_en", K_EN, {12'h0, ALU_FUN});
         if (frame_err)  observe("frame_err", K_FERR, 16'h0);
         if (rx_overrun) observe("rx_overrun", K_OVR, 16'h0);
         if (TX_D_VLD)   observe("tx", K_TX, {8'h0, TX_P_DATA});
         if (fifo_full)  check("no_tx_while_full", 32'(TX_D_VLD), 32'd0);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [DW-1:0] b);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      tick();
      RX_D_VLD  = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // Reset state and divider enable.
      idle(3);
      @(negedge CLK);
      check("reset_outputs", outs, 32'h0);
      tick();
      RST = 1'b0;
      tick();
      @(negedge CLK);
      check("clk_div_en", 32'(clk_div_en), 32'd1);
      tick();

      // Register write.
      push(K_WR, 16'h053C);
      send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
      idle(3);

      // Register read, strobe two cycles after RdEn.
      push(K_RD, 16'h0005);
      push(K_TX, 16'h003C);
      send_byte(8'hBB); send_byte(8'h05);
      idle(1);
      RdData = 8'h3C; RdData_Valid = 1'b1;
      tick();
      RdData_Valid = 1'b0;
      @(negedge CLK);
      check("rd_to_tx_latency", 32'(TX_D_VLD), 32'd1);
      idle(3);

      // Full ALU op with a two-byte result.
      push(K_WR, 16'h0012); push(K_WR, 16'h0134); push(K_EN, 16'h0000);
      push(K_TX, 16'h0046); push(K_TX, 16'h0000);
      send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
      idle(2);
      @(negedge CLK);
      check("clk_en_wait", 32'(CLK_EN), 32'd1);
      tick();
      ALU_OUT = 16'h0046; OUT_Valid = 1'b1;
      tick();
      OUT_Valid = 1'b0;
      @(negedge CLK);
      check("clk_en_drop", 32'(CLK_EN), 32'd0);
      idle(4);

      // ALU op with FIFO back-pressure between the two result bytes.
      push(K_WR, 16'h0056); push(K_WR, 16'h0178); push(K_EN, 16'h0002);
      push(K_TX, 16'h0034); push(K_TX, 16'h0012);
      send_byte(8'hCC); send_byte(8'h56); send_byte(8'h78); send_byte(8'h02);
      idle(2);
      ALU_OUT = 16'h1234; OUT_Valid = 1'b1;
      tick();
      OUT_Valid = 1'b0;
      tick();
      fifo_full = 1'b1;
      idle(5);
      fifo_full = 1'b0;
      idle(4);

      // Unknown opcode.
      push(K_FERR, 16'h0);
      send_byte(8'h77);
      idle(2);

      // Out-of-range address; the following byte is parsed as an opcode.
      push(K_FERR, 16'h0); push(K_FERR, 16'h0);
      send_byte(8'hAA); send_byte(8'h15); send_byte(8'h3C);
      idle(2);

      // Inter-byte timeout while waiting for write data.
      push(K_FERR, 16'h0);
      send_byte(8'hAA); send_byte(8'h05);
      n = 0;
      while (frame_err !== 1'b1 && n < TMO + 50) begin
         tick();
         n++;
      end
      check("timeout_cycles", 32'(n), 32'(TMO));
      idle(2);

      // Overrun during ALU_WAIT; result still returned.
      push(K_EN, 16'h0002); push(K_OVR, 16'h0);
      push(K_TX, 16'h00A5); push(K_TX, 16'h0000);
      send_byte(8'hDD); send_byte(8'h02);
      idle(1);
      send_byte(8'h55);
      idle(2);
      ALU_OUT = 16'h00A5; OUT_Valid = 1'b1;
      tick();
      OUT_Valid = 1'b0;
      idle(4);

      // Reset in the middle of an ALU frame, then a normal write.
      push(K_WR, 16'h0011);
      send_byte(8'hCC); send_byte(8'h11);
      @(negedge CLK);
      #1;
      RST = 1'b1;
      tick();
      @(negedge CLK);
      check("mid_frame_reset", outs, 32'h0);
      tick();
      RST = 1'b0;
      push(K_WR, 16'h01FF);
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
      idle(4);

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
